// File: rtl/fmap_bram_streamer_if.sv
// Output stream of the feature-map streamer: data word plus (chan,row,col) position tags.
interface fmap_bram_streamer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHAN_W     = 5,
  parameter int unsigned ROW_W      = 4,
  parameter int unsigned COL_W      = 4
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CHAN_W-1:0]     m_chan;
  logic [ROW_W-1:0]      m_row;
  logic [COL_W-1:0]      m_col;
  logic                  m_last;

  modport master (output m_valid, m_data, m_chan, m_row, m_col, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_chan, m_row, m_col, m_last, output m_ready);
endinterface

// File: rtl/fmap_bram_streamer.sv
// Sequentially reads a CHW feature map from BRAM and streams it out with position tags,
// using a credit-limited read issue so the output FIFO can never overflow.
module fmap_bram_streamer #(
  parameter int unsigned IN_CHANNELS = 32,
  parameter int unsigned HEIGHT      = 14,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RELU_EN     = 0,
  parameter int unsigned ADDR_W      = $clog2(IN_CHANNELS * HEIGHT * WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  fmap_bram_streamer_if.master  strm
);
  localparam int unsigned TOTAL  = IN_CHANNELS * HEIGHT * WIDTH;
  localparam int unsigned CHAN_W = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W  = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                state, state_nxt;
  logic                  busy_c, done_c;
  logic [ADDR_W-1:0]     rd_addr;
  logic [RD_LAT-1:0]     vld_sr;
  logic [INF_W-1:0]      inflight_c;
  logic                  issue_c, last_addr_c, push_c, pop_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt, fifo_cnt_nxt;
  logic                  valid_q;
  logic [ADDR_W-1:0]     out_idx;
  logic [CHAN_W-1:0]     chan_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic                  last_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads outstanding: the one presented this cycle plus those in the latency pipe
  always_comb begin
    inflight_c = INF_W'(bram_en);
    for (int unsigned i = 0; i < RD_LAT; i++) inflight_c = inflight_c + INF_W'(vld_sr[i]);
  end

  assign push_c       = vld_sr[RD_LAT-1];
  assign pop_c        = valid_q & strm.m_ready;
  assign last_addr_c  = (rd_addr == ADDR_W'(TOTAL - 1));
  // A pop this cycle frees a slot, which keeps one word per cycle at RD_LAT=2
  assign issue_c      = (state == RUN) &&
                        ((32'(fifo_cnt) + 32'(inflight_c) - 32'(pop_c)) < FIFO_DEPTH);
  assign fifo_cnt_nxt = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
  assign wdata_c      = ((RELU_EN != 0) && bram_dout[DATA_WIDTH-1]) ? '0 : bram_dout;

  // State register plus registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_c;
      done  <= done_c;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue_c && last_addr_c) state_nxt = DRAIN;
      DRAIN:   if ((fifo_cnt == '0) && (inflight_c == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    if ((state_nxt == RUN) || (state_nxt == DRAIN)) busy_c = 1'b1;
    if (state_nxt == DONE) done_c = 1'b1;
  end

  // Read address generation and read-latency tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en   <= 1'b0;
      bram_addr <= '0;
      rd_addr   <= '0;
      vld_sr    <= '0;
    end else begin
      bram_en <= issue_c;
      vld_sr  <= (vld_sr << 1) | RD_LAT'(bram_en);
      if (state == IDLE) begin
        rd_addr   <= '0;
        bram_addr <= '0;
      end else if (issue_c) begin
        bram_addr <= rd_addr;
        if (!last_addr_c) rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wdata_c;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt_nxt;
      valid_q  <= (fifo_cnt_nxt != '0);
    end
  end

  // Output position tags, col fastest then row then chan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx <= '0;
      chan_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else if (state == IDLE) begin
      out_idx <= '0;
      chan_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= (TOTAL == 1);
    end else if (pop_c) begin
      last_q  <= ((32'(out_idx) + 32'd2) == TOTAL);
      out_idx <= last_q ? '0 : out_idx + 1'b1;
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_q <= '0;
        if (row_q == ROW_W'(HEIGHT - 1)) begin
          row_q  <= '0;
          chan_q <= (chan_q == CHAN_W'(IN_CHANNELS - 1)) ? '0 : chan_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign strm.m_valid = valid_q;
  assign strm.m_data  = mem[rd_ptr];
  assign strm.m_chan  = chan_q;
  assign strm.m_row   = row_q;
  assign strm.m_col   = col_q;
  assign strm.m_last  = last_q;

endmodule
